// File: rtl/cache_axi_arbiter_if.sv
// cache_axi_arbiter_if: read request/return and write request/response bundle shared by caches and the AXI bridge.
interface cache_axi_arbiter_if;
  logic         rd_req;
  logic [1:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         bvalid;
  modport master (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy, bvalid
  );
  modport slave (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy, bvalid
  );
endinterface

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: round-robin read arbitration of ICache/DCache onto one bridge,
// DCache write pass-through with an outstanding-write counter acting as a RAW barrier.
module cache_axi_arbiter #(
  parameter int MAX_WR_OUT = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic resetn,
  cache_axi_arbiter_if.slave  ic,
  cache_axi_arbiter_if.slave  dc,
  cache_axi_arbiter_if.master br,
  output logic wr_idle_o,
  output logic err_bresp_o
);
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA} state_e;
  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             err_q, err_d;
  logic             wr_ok, wr_hs, bdec, el0, el1, in_req, in_data;
  assign wr_ok   = wr_cnt_q < CNT_W'(MAX_WR_OUT);
  assign wr_hs   = br.wr_req & br.wr_rdy;
  assign bdec    = br.bvalid & (wr_cnt_q != '0);
  assign el0     = ic.rd_req;
  // DCache reads wait until every write has been acknowledged, including one being accepted now
  assign el1     = dc.rd_req & (wr_cnt_q == '0) & ~wr_hs;
  assign in_req  = resetn & (state_q == R_REQ);
  assign in_data = resetn & (state_q == R_DATA);
  assign br.rd_req   = in_req;
  assign br.rd_type  = grant_q ? dc.rd_type : ic.rd_type;
  assign br.rd_addr  = grant_q ? dc.rd_addr : ic.rd_addr;
  assign ic.rd_rdy   = in_req & ~grant_q & br.rd_rdy;
  assign dc.rd_rdy   = in_req & grant_q & br.rd_rdy;
  assign ic.ret_valid = in_data & ~grant_q & br.ret_valid;
  assign dc.ret_valid = in_data & grant_q & br.ret_valid;
  assign ic.ret_last = br.ret_last;
  assign dc.ret_last = br.ret_last;
  assign ic.ret_data = br.ret_data;
  assign dc.ret_data = br.ret_data;
  assign br.wr_req   = resetn & dc.wr_req & wr_ok;
  assign br.wr_type  = dc.wr_type;
  assign br.wr_addr  = dc.wr_addr;
  assign br.wr_wstrb = dc.wr_wstrb;
  assign br.wr_data  = dc.wr_data;
  assign dc.wr_rdy   = resetn & br.wr_rdy & wr_ok;
  assign ic.wr_rdy   = 1'b0;
  assign ic.bvalid   = 1'b0;
  assign dc.bvalid   = 1'b0;
  assign wr_idle_o   = wr_cnt_q == '0;
  assign err_bresp_o = err_q;
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    prio_d   = prio_q;
    wr_cnt_d = wr_cnt_q + CNT_W'(wr_hs) - CNT_W'(bdec);
    err_d    = err_q | (br.bvalid & (wr_cnt_q == '0));
    if (state_q == R_IDLE && (el0 || el1)) begin
      state_d = R_REQ;
      grant_d = (el0 && el1) ? prio_q : el1;
    end
    if (state_q == R_REQ && br.rd_rdy) state_d = R_DATA;
    if (state_q == R_DATA && br.ret_valid && br.ret_last) begin
      state_d = R_IDLE;
      prio_d  = ~grant_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= R_IDLE;
      grant_q  <= 1'b0;
      prio_q   <= 1'b0;
      wr_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      prio_q   <= prio_d;
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_cache_axi_arbiter.sv
// tb_cache_axi_arbiter: directed vectors with hand-computed expectations for the cache/AXI arbiter.
module tb_cache_axi_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic wr_idle, err_bresp;
  int   n_vec = 0;
  int   n_miss = 0;
  cache_axi_arbiter_if ic();
  cache_axi_arbiter_if dc();
  cache_axi_arbiter_if br();
  cache_axi_arbiter #(.MAX_WR_OUT(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn), .ic(ic), .dc(dc), .br(br),
    .wr_idle_o(wr_idle), .err_bresp_o(err_bresp)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic beats(input int n, input bit g, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      br.ret_valid = 1'b1;
      br.ret_last  = (i == n - 1);
      br.ret_data  = base * (i + 1);
      #1;
      chk(g ? "dc_ret_valid" : "ic_ret_valid", g ? dc.ret_valid : ic.ret_valid, 1);
      chk(g ? "ic_ret_valid_idle" : "dc_ret_valid_idle", g ? ic.ret_valid : dc.ret_valid, 0);
      chk("ret_data", g ? dc.ret_data : ic.ret_data, base * (i + 1));
      chk("ret_last", g ? dc.ret_last : ic.ret_last, (i == n - 1));
      tick();
    end
    br.ret_valid = 1'b0;
    br.ret_last  = 1'b0;
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask
  initial begin
    {ic.rd_req, ic.rd_type, ic.rd_addr, ic.wr_req, ic.wr_type, ic.wr_addr, ic.wr_wstrb, ic.wr_data} = '0;
    {dc.rd_req, dc.rd_type, dc.rd_addr, dc.wr_req, dc.wr_type, dc.wr_addr, dc.wr_wstrb, dc.wr_data} = '0;
    {br.rd_rdy, br.ret_valid, br.ret_last, br.ret_data, br.wr_rdy, br.bvalid} = '0;
    // reset: all request/ready outputs held low even with live inputs
    dc.wr_req = 1'b1;
    br.wr_rdy = 1'b1;
    ic.rd_req = 1'b1;
    tick();
    tick();
    chk("rst_rd_req", br.rd_req, 0);
    chk("rst_wr_req", br.wr_req, 0);
    chk("rst_dc_wr_rdy", dc.wr_rdy, 0);
    chk("rst_wr_idle", wr_idle, 1);
    chk("rst_err", err_bresp, 0);
    {dc.wr_req, br.wr_rdy, ic.rd_req} = '0;
    resetn = 1'b1;
    tick();
    // 1: lone ICache burst, rd_rdy on the 2nd request cycle
    ic.rd_req = 1'b1;
    ic.rd_addr = 32'h100;
    ic.rd_type = 2'd3;
    tick();
    chk("t1_rd_req", br.rd_req, 1);
    chk("t1_rd_addr", br.rd_addr, 32'h100);
    chk("t1_rd_type", br.rd_type, 3);
    chk("t1_ic_rdy_lo", ic.rd_rdy, 0);
    tick();
    br.rd_rdy = 1'b1;
    #1;
    chk("t1_ic_rdy", ic.rd_rdy, 1);
    chk("t1_dc_rdy", dc.rd_rdy, 0);
    tick();
    ic.rd_req = 1'b0;
    br.rd_rdy = 1'b0;
    beats(4, 0, 32'h11);
    chk("t1_idle", br.rd_req, 0);
    // 2: same-cycle tie from reset, then DCache, then tie goes back to ICache
    do_reset();
    ic.rd_req = 1'b1;
    ic.rd_addr = 32'h200;
    dc.rd_req = 1'b1;
    dc.rd_addr = 32'h300;
    tick();
    chk("t2_first_ic", br.rd_addr, 32'h200);
    br.rd_rdy = 1'b1;
    #1;
    chk("t2_ic_rdy", ic.rd_rdy, 1);
    chk("t2_dc_rdy_lo", dc.rd_rdy, 0);
    tick();
    ic.rd_req = 1'b0;
    br.rd_rdy = 1'b0;
    beats(2, 0, 32'h21);
    tick();
    chk("t2_then_dc", br.rd_addr, 32'h300);
    br.rd_rdy = 1'b1;
    #1;
    chk("t2_dc_rdy", dc.rd_rdy, 1);
    chk("t2_ic_rdy_lo", ic.rd_rdy, 0);
    tick();
    br.rd_rdy = 1'b0;
    beats(2, 1, 32'h31);
    ic.rd_req = 1'b1;
    tick();
    chk("t2_tie_ic", br.rd_addr, 32'h200);
    br.rd_rdy = 1'b1;
    tick();
    {ic.rd_req, dc.rd_req, br.rd_rdy} = '0;
    beats(1, 0, 32'h41);
    // 3: write barrier blocks DCache read; ICache read proceeds
    dc.wr_req = 1'b1;
    dc.wr_addr = 32'h1000;
    dc.wr_type = 3'd4;
    dc.wr_wstrb = 4'hf;
    dc.wr_data = 128'h0123_4567_89ab_cdef;
    br.wr_rdy = 1'b1;
    #1;
    chk("t3_wr_req", br.wr_req, 1);
    chk("t3_wr_addr", br.wr_addr, 32'h1000);
    chk("t3_wr_data", br.wr_data, 128'h0123_4567_89ab_cdef);
    chk("t3_dc_wr_rdy", dc.wr_rdy, 1);
    tick();
    dc.wr_req = 1'b0;
    br.wr_rdy = 1'b0;
    dc.rd_req = 1'b1;
    dc.rd_addr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_blocked", br.rd_req, 0);
      chk("t3_wr_busy", wr_idle, 0);
      tick();
    end
    ic.rd_req = 1'b1;
    ic.rd_addr = 32'h500;
    tick();
    chk("t3_ic_granted", br.rd_req, 1);
    chk("t3_ic_addr", br.rd_addr, 32'h500);
    br.rd_rdy = 1'b1;
    tick();
    ic.rd_req = 1'b0;
    br.rd_rdy = 1'b0;
    beats(1, 0, 32'h51);
    chk("t3_still_blocked", br.rd_req, 0);
    br.bvalid = 1'b1;
    tick();
    br.bvalid = 1'b0;
    #1;
    chk("t3_drained", wr_idle, 1);
    chk("t3_rd_req_lag", br.rd_req, 0);
    tick();
    chk("t3_dc_rd_req", br.rd_req, 1);
    chk("t3_dc_addr", br.rd_addr, 32'h400);
    br.rd_rdy = 1'b1;
    tick();
    dc.rd_req = 1'b0;
    br.rd_rdy = 1'b0;
    beats(1, 1, 32'h61);
    // 4: outstanding-write limit and simultaneous accept+response
    dc.wr_req = 1'b1;
    br.wr_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_wr_acc", br.wr_req, 1);
      tick();
    end
    br.bvalid = 1'b1;
    #1;
    chk("t4_wr_with_b", br.wr_req, 1);
    tick();
    br.bvalid = 1'b0;
    #1;
    chk("t4_4th_wr", br.wr_req, 1);
    tick();
    chk("t4_full_wr_req", br.wr_req, 0);
    chk("t4_full_rdy", dc.wr_rdy, 0);
    dc.wr_req = 1'b0;
    br.wr_rdy = 1'b0;
    br.bvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_busy", wr_idle, 0);
      tick();
    end
    chk("t4_idle", wr_idle, 1);
    chk("t4_no_err", err_bresp, 0);
    tick();
    br.bvalid = 1'b0;
    #1;
    chk("t4_err", err_bresp, 1);
    chk("t4_cnt0", wr_idle, 1);
    // 5: uncached single-beat DCache read
    dc.rd_req = 1'b1;
    dc.rd_type = 2'd2;
    dc.rd_addr = 32'h2000;
    tick();
    chk("t5_type", br.rd_type, 2);
    br.rd_rdy = 1'b1;
    tick();
    dc.rd_req = 1'b0;
    br.rd_rdy = 1'b0;
    br.ret_valid = 1'b1;
    br.ret_last = 1'b1;
    br.ret_data = 32'hDEADBEEF;
    #1;
    chk("t5_valid", dc.ret_valid, 1);
    chk("t5_data", dc.ret_data, 32'hDEADBEEF);
    chk("t5_ic_quiet", ic.ret_valid, 0);
    tick();
    chk("t5_dropped", dc.ret_valid, 0);
    chk("t5_idle", br.rd_req, 0);
    br.ret_valid = 1'b0;
    br.ret_last = 1'b0;
    // 6: reset in the middle of an ICache burst with a write outstanding
    dc.wr_req = 1'b1;
    br.wr_rdy = 1'b1;
    ic.rd_req = 1'b1;
    ic.rd_addr = 32'h600;
    tick();
    dc.wr_req = 1'b0;
    br.wr_rdy = 1'b0;
    br.rd_rdy = 1'b1;
    tick();
    ic.rd_req = 1'b0;
    br.rd_rdy = 1'b0;
    br.ret_valid = 1'b1;
    br.ret_data = 32'h71;
    #1;
    chk("t6_beat1", ic.ret_valid, 1);
    chk("t6_cnt1", wr_idle, 0);
    tick();
    resetn = 1'b0;
    #1;
    chk("t6_rst_gate", ic.ret_valid, 0);
    tick();
    resetn = 1'b1;
    #1;
    chk("t6_after_rst", ic.ret_valid, 0);
    chk("t6_cnt_clr", wr_idle, 1);
    chk("t6_err_clr", err_bresp, 0);
    tick();
    chk("t6_still_dropped", ic.ret_valid, 0);
    br.ret_valid = 1'b0;
    dc.rd_req = 1'b1;
    dc.rd_addr = 32'h3000;
    tick();
    chk("t6_dc_req", br.rd_req, 1);
    chk("t6_dc_addr", br.rd_addr, 32'h3000);
    br.rd_rdy = 1'b1;
    #1;
    chk("t6_dc_rdy", dc.rd_rdy, 1);
    tick();
    dc.rd_req = 1'b0;
    br.rd_rdy = 1'b0;
    beats(1, 1, 32'h81);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
